otp_stream_engine: RTL and testbench

- Parametrised successor to the fixed-width shifter/cypher pair.
- Generates a one-time-pad keystream from a loadable key using a Galois LFSR, then XORs it onto a valid/ready word stream.
- The operation is symmetric, so one instance encrypts and a second instance loaded with the same key decrypts.
- Sits between a message source and a sink. Adds key warm-up, back-pressure and word counting, which the previous generation lacked.

---
 rtl/otp_stream_if.sv | 21 ++
 rtl/otp_stream_engine.sv | 98 +++++++++
 tb/tb_otp_stream_engine.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otp_stream_if.sv
// Valid/ready word stream bundle for the keystream engine: message input side and cipher output side.
interface otp_stream_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // master: the surrounding source/sink; slave: the engine
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/otp_stream_engine.sv
// One-time-pad stream engine: Galois LFSR keystream XORed onto a valid/ready word stream,
// with key warm-up, back-pressure and a per-key accepted-word counter.
module otp_stream_engine #(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter int                WARMUP = 4,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [LFSR_W-1:0] key,
    otp_stream_if.slave       s,
    output logic              keyed,
    output logic [CNT_W-1:0]  word_count
);
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {IDLE, KEYING, RUN} state_t;

    state_t            state_reg;
    logic [LFSR_W-1:0] lfsr_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [WW-1:0]     warm_reg;

    logic [LFSR_W-1:0] lfsr_next;
    logic [LFSR_W-1:0] key_seed;
    logic [DATA_W-1:0] keystream;
    logic              in_ready_w;
    logic              in_fire;

    // One keystream word consumes DATA_W single-bit Galois steps, flattened into one cycle.
    function automatic logic [LFSR_W-1:0] advance_word(input logic [LFSR_W-1:0] s_in);
        logic [LFSR_W-1:0] st;
        st = s_in;
        for (int i = 0; i < DATA_W; i++) begin
            if (st[0])
                st = (st >> 1) ^ TAPS;
            else
                st = st >> 1;
        end
        return st;
    endfunction

    assign lfsr_next  = advance_word(lfsr_reg);
    assign keystream  = lfsr_reg[DATA_W-1:0];
    // An all-zero LFSR never leaves zero, so a zero key is promoted to 1.
    assign key_seed   = (key == '0) ? LFSR_W'(1) : key;
    assign in_ready_w = (state_reg == RUN) && !key_load && !reset
                        && (!out_valid_reg || s.out_ready);
    assign in_fire    = s.in_valid && in_ready_w;

    assign s.in_ready  = in_ready_w;
    assign s.out_valid = out_valid_reg;
    assign s.out_data  = out_data_reg;
    assign keyed       = (state_reg == RUN);
    assign word_count  = count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            lfsr_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
            warm_reg      <= '0;
        end else if (key_load) begin
            lfsr_reg      <= key_seed;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
            warm_reg      <= '0;
            state_reg     <= (WARMUP > 0) ? KEYING : RUN;
        end else begin
            case (state_reg)
                KEYING: begin
                    lfsr_reg <= lfsr_next;
                    warm_reg <= warm_reg + 1'b1;
                    if (int'(warm_reg) == WARMUP - 1)
                        state_reg <= RUN;
                end
                RUN: begin
                    if (in_fire) begin
                        out_data_reg  <= s.in_data ^ keystream;
                        out_valid_reg <= 1'b1;
                        lfsr_reg      <= lfsr_next;
                        count_reg     <= count_reg + 1'b1;
                    end else if (out_valid_reg && s.out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_otp_stream_engine.sv
// Directed bench for otp_stream_engine: a spec-level keystream model checks u0 every cycle,
// and an encryptor/decryptor pair checks the round trip.
module tb_otp_stream_engine;
    localparam int W0 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        key_load0;
    logic [15:0] key0;
    logic        keyed0;
    logic [15:0] wc0;

    logic        rt_key_load;
    logic [15:0] rt_key;
    logic        enc_keyed, dec_keyed;
    logic [15:0] enc_wc, dec_wc;

    otp_stream_if #(.DATA_W(8)) if0 ();
    otp_stream_if #(.DATA_W(8)) enc_if ();
    otp_stream_if #(.DATA_W(8)) dec_if ();

    otp_stream_engine #(.DATA_W(8), .LFSR_W(16), .TAPS(16'hB400), .WARMUP(W0), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .key_load(key_load0), .key(key0),
        .s(if0.slave), .keyed(keyed0), .word_count(wc0)
    );
    otp_stream_engine #(.DATA_W(8), .LFSR_W(16), .TAPS(16'hB400), .WARMUP(4), .CNT_W(16)) u_enc (
        .clk(clk), .reset(reset), .key_load(rt_key_load), .key(rt_key),
        .s(enc_if.slave), .keyed(enc_keyed), .word_count(enc_wc)
    );
    otp_stream_engine #(.DATA_W(8), .LFSR_W(16), .TAPS(16'hB400), .WARMUP(4), .CNT_W(16)) u_dec (
        .clk(clk), .reset(reset), .key_load(rt_key_load), .key(rt_key),
        .s(dec_if.slave), .keyed(dec_keyed), .word_count(dec_wc)
    );

    assign dec_if.in_valid  = enc_if.out_valid;
    assign dec_if.in_data   = enc_if.out_data;
    assign enc_if.out_ready = dec_if.in_ready;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            miss_cnt++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keystream word number idx of a key: the seed stepped idx*8 times, low byte taken.
    function automatic logic [7:0] ks_word(input logic [15:0] seed, input int idx);
        logic [15:0] st;
        st = seed;
        for (int i = 0; i < idx * 8; i++)
            st = st[0] ? ((st >> 1) ^ 16'hB400) : (st >> 1);
        return st[7:0];
    endfunction

    // Model of u0: the key seed, words accepted since load and cycles since load fully define it.
    bit          mon_en = 1'b0;
    bit          m_active = 1'b0;
    logic [15:0] m_seed = 16'h0;
    int          m_n = 0;
    int          m_since = 0;
    bit          m_ov = 1'b0;
    logic [7:0]  m_od = 8'h0;

    always @(negedge clk) begin : model
        bit m_keyed;
        bit m_ir;
        if (mon_en) begin
            m_keyed = m_active && (m_since >= W0);
            m_ir    = m_keyed && !key_load0 && !reset && (!m_ov || if0.out_ready);
            check("mdl_in_ready",  32'(if0.in_ready),  32'(m_ir));
            check("mdl_out_valid", 32'(if0.out_valid), 32'(m_ov));
            check("mdl_out_data",  32'(if0.out_data),  32'(m_od));
            check("mdl_keyed",     32'(keyed0),        32'(m_keyed));
            check("mdl_word_count", 32'(wc0),          32'(m_n & 16'hFFFF));
            if (if0.out_valid && if0.out_ready)
                $display("u0 word out data=%h count=%0d", if0.out_data, wc0);
            if (reset) begin
                m_active = 1'b0; m_ov = 1'b0; m_od = 8'h0; m_n = 0; m_since = 0;
            end else if (key_load0) begin
                m_active = 1'b1; m_seed = (key0 == 16'h0) ? 16'h1 : key0;
                m_n = 0; m_since = 0; m_ov = 1'b0;
            end else if (m_active && m_since < W0) begin
                m_since++;
            end else if (m_keyed) begin
                if (if0.in_valid && m_ir) begin
                    m_od = if0.in_data ^ ks_word(m_seed, W0 + m_n);
                    m_n++;
                    m_ov = 1'b1;
                end else if (m_ov && if0.out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    // Round-trip scoreboard: plaintext accepted by the encryptor must leave the decryptor in order.
    logic [7:0] sent_q[$];
    bit         rt_in_fire = 1'b0;
    int         rt_rx = 0;

    always @(negedge clk) begin : rt_sb
        logic [7:0] exp_w;
        rt_in_fire = enc_if.in_valid && enc_if.in_ready;
        if (rt_in_fire)
            sent_q.push_back(enc_if.in_data);
        if (dec_if.out_valid && dec_if.out_ready) begin
            rt_rx++;
            if (sent_q.size() == 0) begin
                check("rt_unexpected_word", 32'(dec_if.out_data), 32'hFFFF_FFFF);
            end else begin
                exp_w = sent_q.pop_front();
                check("rt_word", 32'(dec_if.out_data), 32'(exp_w));
                $display("rt word %0d plain=%h", rt_rx, dec_if.out_data);
            end
        end
    end

    logic [7:0] hold_d;
    logic [15:0] hold_wc;
    logic [7:0] rt_words[64];
    int rt_idx;

    initial begin
        reset = 1'b1; key_load0 = 1'b0; key0 = '0;
        rt_key_load = 1'b0; rt_key = '0;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
        enc_if.in_valid = 1'b0; enc_if.in_data = '0; dec_if.out_ready = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        check("rst_in_ready", 32'(if0.in_ready), 0);
        check("rst_out_valid", 32'(if0.out_valid), 0);
        check("rst_word_count", 32'(wc0), 0);

        // Key 0x00AA, no warm-up: keystream 0xAA, 0x90
        key0 = 16'h00AA; key_load0 = 1'b1; step(); key_load0 = 1'b0;
        check("t1_keyed", 32'(keyed0), 1);
        if0.out_ready = 1'b1; if0.in_valid = 1'b1; if0.in_data = 8'h55; step();
        check("t1_valid0", 32'(if0.out_valid), 1);
        check("t1_word0", 32'(if0.out_data), 32'hFF);
        step();
        check("t1_word1", 32'(if0.out_data), 32'hC5);
        check("t1_count", 32'(wc0), 2);
        if0.in_valid = 1'b0; step();

        // Zero key promoted to 1: keystream 0x01 then 0x68
        key0 = 16'h0000; key_load0 = 1'b1; step(); key_load0 = 1'b0;
        if0.in_valid = 1'b1; if0.in_data = 8'h00; step();
        check("t2_word0", 32'(if0.out_data), 32'h01);
        step();
        check("t2_word1", 32'(if0.out_data), 32'h68);
        if0.in_valid = 1'b0; step();

        // Back-pressure: first keystream word of 0x1234 is 0x34
        key0 = 16'h1234; key_load0 = 1'b1; step(); key_load0 = 1'b0;
        if0.out_ready = 1'b0; if0.in_valid = 1'b1; if0.in_data = 8'h3C; step();
        check("t3_word0", 32'(if0.out_data), 32'h08);
        hold_d = if0.out_data; hold_wc = wc0;
        if0.in_data = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_data", 32'(if0.out_data), 32'(hold_d));
            check("t3_hold_ready", 32'(if0.in_ready), 0);
            check("t3_hold_count", 32'(wc0), 32'(hold_wc));
        end
        if0.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if0.in_data = 8'(i * 17 + 3);
            if0.in_valid = (i % 3 != 2);
            step();
        end

        // Rekey while a word is pending and another is offered
        if0.in_valid = 1'b1; if0.in_data = 8'h77; step();
        check("t4_pending", 32'(if0.out_valid), 1);
        key0 = 16'hBEEF; key_load0 = 1'b1; if0.in_data = 8'h99; #1;
        check("t4_ready_on_load", 32'(if0.in_ready), 0);
        step(); key_load0 = 1'b0;
        check("t4_valid_cleared", 32'(if0.out_valid), 0);
        check("t4_count_cleared", 32'(wc0), 0);
        if0.in_data = 8'h00; step();
        check("t4_new_key_word0", 32'(if0.out_data), 32'hEF);
        check("t4_count_one", 32'(wc0), 1);
        for (int i = 0; i < 6; i++) begin
            if0.in_data = 8'(8'hA0 + i); step();
        end

        // Reset mid-stream
        reset = 1'b1; step(); reset = 1'b0;
        check("t5_out_valid", 32'(if0.out_valid), 0);
        check("t5_out_data", 32'(if0.out_data), 0);
        check("t5_keyed", 32'(keyed0), 0);
        check("t5_count", 32'(wc0), 0);
        for (int i = 0; i < 3; i++) begin
            check("t5_idle_ready", 32'(if0.in_ready), 0);
            step();
        end
        key0 = 16'h5A5A; key_load0 = 1'b1; step(); key_load0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if0.in_data = 8'(8'h10 * i); step();
        end
        if0.in_valid = 1'b0; step();

        // Round trip through a WARMUP=4 pair
        for (int i = 0; i < 64; i++) rt_words[i] = 8'($urandom);
        rt_key = 16'hACE1; rt_key_load = 1'b1; step(); rt_key_load = 1'b0;
        check("rt_keyed_at_load", 32'(enc_keyed), 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("rt_enc_keyed", 32'(enc_keyed), 32'(i == 4));
            check("rt_dec_keyed", 32'(dec_keyed), 32'(i == 4));
        end
        rt_idx = 0;
        for (int cyc = 0; cyc < 3000 && rt_rx < 64; cyc++) begin
            if (rt_idx < 64) begin
                enc_if.in_valid = ($urandom_range(0, 3) != 0);
                enc_if.in_data  = rt_words[rt_idx];
            end else begin
                enc_if.in_valid = 1'b0;
            end
            dec_if.out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (rt_in_fire) rt_idx++;
        end
        check("rt_received", 32'(rt_rx), 64);
        check("rt_enc_count", 32'(enc_wc), 64);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
